// File: rtl/multi_key_debouncer.sv
// Multi-channel push-button debouncer. Each channel has a 2-flop synchronizer,
// a hysteretic shift filter, press/release pulses, auto-repeat and a long-press flag.
module multi_key_debouncer #(
  parameter int unsigned CH_NUM             = 4,
  parameter int unsigned BITS_NUM           = 4,
  parameter int unsigned ACTIVE_LOW         = 0,
  parameter int unsigned REPEAT_START_DELAY = 50,
  parameter int unsigned REPEAT_PERIOD      = 10,
  parameter int unsigned LONG_DELAY         = 200
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              REP_CE,
  input  logic [CH_NUM-1:0] S_IN,
  input  logic [CH_NUM-1:0] REP_EN,
  output logic [CH_NUM-1:0] KEY_EN,
  output logic [CH_NUM-1:0] KEY_PRESS,
  output logic [CH_NUM-1:0] KEY_REL,
  output logic [CH_NUM-1:0] KEY_UP,
  output logic [CH_NUM-1:0] KEY_LONG
);

  // The oldest filter sample is never examined, so only BITS_NUM-1 bits are kept.
  localparam int unsigned SR_W    = BITS_NUM - 1;
  localparam int unsigned REP_MAX = (REPEAT_START_DELAY > REPEAT_PERIOD) ?
                                    REPEAT_START_DELAY : REPEAT_PERIOD;
  localparam int unsigned RC_W    = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam int unsigned HC_W    = $clog2(LONG_DELAY + 1);
  localparam logic        INV     = (ACTIVE_LOW != 0);

  logic [CH_NUM-1:0] sync1_q;
  logic [CH_NUM-1:0] sync2_q;
  logic [SR_W-1:0]   sr_q [CH_NUM];
  logic [SR_W-1:0]   sr_d [CH_NUM];
  logic [RC_W-1:0]   rc_q [CH_NUM];
  logic [RC_W-1:0]   rc_d [CH_NUM];
  logic [HC_W-1:0]   hc_q [CH_NUM];
  logic [HC_W-1:0]   hc_d [CH_NUM];

  logic [CH_NUM-1:0] set_c;
  logic [CH_NUM-1:0] clr_c;
  logic [CH_NUM-1:0] en_d;
  logic [CH_NUM-1:0] press_d;
  logic [CH_NUM-1:0] rel_d;
  logic [CH_NUM-1:0] up_d;
  logic [CH_NUM-1:0] long_d;

  // Per-channel next state: filter shift, debounced state, repeat and hold counters.
  always_comb begin
    sr_d    = sr_q;
    rc_d    = rc_q;
    hc_d    = hc_q;
    set_c   = '0;
    clr_c   = '0;
    en_d    = KEY_EN;
    press_d = '0;
    rel_d   = '0;
    up_d    = '0;
    long_d  = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      set_c[i] = CE & sync2_q[i] & (&sr_q[i]) & ~KEY_EN[i];
      clr_c[i] = CE & ~sync2_q[i] & ~(|sr_q[i]) & KEY_EN[i];
      if (CE) begin
        sr_d[i] = (sr_q[i] << 1) | SR_W'(sync2_q[i]);
      end
      if (set_c[i]) begin
        // Press: load the start delay and restart the hold count; beats any REP_CE.
        en_d[i]    = 1'b1;
        press_d[i] = 1'b1;
        up_d[i]    = 1'b1;
        rc_d[i]    = RC_W'(REPEAT_START_DELAY - 1);
        hc_d[i]    = '0;
      end else if (clr_c[i]) begin
        // Release: counters are ignored on this edge.
        en_d[i]  = 1'b0;
        rel_d[i] = 1'b1;
        hc_d[i]  = '0;
      end else if (KEY_EN[i]) begin
        if (REP_CE) begin
          if (REP_EN[i]) begin
            if (rc_q[i] == '0) begin
              up_d[i] = 1'b1;
              rc_d[i] = RC_W'(REPEAT_PERIOD - 1);
            end else begin
              rc_d[i] = rc_q[i] - RC_W'(1);
            end
          end
          if (hc_q[i] != HC_W'(LONG_DELAY)) begin
            hc_d[i] = hc_q[i] + HC_W'(1);
          end
        end
      end else begin
        hc_d[i] = '0;
      end
      long_d[i] = (hc_q[i] == HC_W'(LONG_DELAY)) & en_d[i];
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sr_q      <= '{default: '0};
      rc_q      <= '{default: '0};
      hc_q      <= '{default: '0};
      KEY_EN    <= '0;
      KEY_PRESS <= '0;
      KEY_REL   <= '0;
      KEY_UP    <= '0;
      KEY_LONG  <= '0;
    end else begin
      sync1_q   <= S_IN ^ {CH_NUM{INV}};
      sync2_q   <= sync1_q;
      sr_q      <= sr_d;
      rc_q      <= rc_d;
      hc_q      <= hc_d;
      KEY_EN    <= en_d;
      KEY_PRESS <= press_d;
      KEY_REL   <= rel_d;
      KEY_UP    <= up_d;
      KEY_LONG  <= long_d;
    end
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench for multi_key_debouncer: reset, bounce filtering, auto-repeat,
// long press, active-low inputs, simultaneous presses and mid-hold clear.
module tb_multi_key_debouncer;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       CE;
  logic       REP_CE;
  logic [3:0] s_a;
  logic [3:0] s_b;
  logic [3:0] rep_en;

  logic [3:0] en_a, press_a, rel_a, up_a, long_a;
  logic [3:0] en_b, press_b, rel_b, up_b, long_b;

  int n_checks = 0;
  int n_errors = 0;

  multi_key_debouncer #(
    .CH_NUM(4), .BITS_NUM(4), .ACTIVE_LOW(0),
    .REPEAT_START_DELAY(3), .REPEAT_PERIOD(2), .LONG_DELAY(5)
  ) dut_a (
    .CLK(CLK), .CLR(CLR), .CE(CE), .REP_CE(REP_CE), .S_IN(s_a), .REP_EN(rep_en),
    .KEY_EN(en_a), .KEY_PRESS(press_a), .KEY_REL(rel_a), .KEY_UP(up_a), .KEY_LONG(long_a)
  );

  multi_key_debouncer #(
    .CH_NUM(4), .BITS_NUM(4), .ACTIVE_LOW(1),
    .REPEAT_START_DELAY(3), .REPEAT_PERIOD(2), .LONG_DELAY(5)
  ) dut_b (
    .CLK(CLK), .CLR(CLR), .CE(CE), .REP_CE(REP_CE), .S_IN(s_b), .REP_EN(rep_en),
    .KEY_EN(en_b), .KEY_PRESS(press_b), .KEY_REL(rel_b), .KEY_UP(up_b), .KEY_LONG(long_b)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       clr;
    logic [3:0] s;
    logic [3:0] en;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] up;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int n, input logic clr, input logic [3:0] s,
                              input logic [3:0] en, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] up);
    vec_t v;
    v.clr = clr; v.s = s; v.en = en; v.pr = pr; v.rl = rl; v.up = up;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rce);
    REP_CE = rce;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    CLR = 1'b1; CE = 1'b1; REP_CE = 1'b0;
    s_a = 4'hF; s_b = 4'hF; rep_en = 4'hF;

    // Reset with all keys held, then press after 6 edges, then release all.
    add(3, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    add(5, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF);
    add(2, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    add(5, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Bounce 1,0,1,1,0 then steady 1s on ch0.
    add(1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(2, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(5, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1);
    add(1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    // Three zeros then a one: hysteresis keeps the key down.
    add(3, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(7, 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    // Clean release of ch0.
    add(5, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    foreach (tbl[i]) begin
      CLR = tbl[i].clr;
      s_a = tbl[i].s;
      cyc(1'b0);
      chk($sformatf("row%0d en", i),    en_a,    tbl[i].en);
      chk($sformatf("row%0d press", i), press_a, tbl[i].pr);
      chk($sformatf("row%0d rel", i),   rel_a,   tbl[i].rl);
      chk($sformatf("row%0d up", i),    up_a,    tbl[i].up);
      chk($sformatf("row%0d long", i),  long_a,  4'h0);
    end
    chk("b idle en", en_b, 4'h0);
    chk("b idle up", up_b, 4'h0);

    // Auto-repeat on ch1: start delay 3 ticks, period 2, REP_EN gating.
    s_a = 4'b0010;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("rep press", press_a & 4'b0010, (c == 6) ? 4'b0010 : 4'b0000);
      chk("rep press up", up_a & 4'b0010, (c == 6) ? 4'b0010 : 4'b0000);
    end
    for (int k = 1; k <= 13; k++) begin
      rep_en = (k >= 9 && k <= 12) ? 4'b1101 : 4'hF;
      for (int q = 0; q < 3; q++) begin
        cyc(1'b0);
        chk("rep quiet", up_a & 4'b0010, 4'b0000);
      end
      cyc(1'b1);
      chk($sformatf("rep tick%0d", k), up_a & 4'b0010,
          (k == 3 || k == 5 || k == 7 || k == 13) ? 4'b0010 : 4'b0000);
      if (k >= 9 && k <= 12) chk("rep gated en", en_a & 4'b0010, 4'b0010);
    end
    cyc(1'b0);
    chk("rep after", up_a & 4'b0010, 4'b0000);
    s_a = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("rep rel", rel_a & 4'b0010, (c == 6) ? 4'b0010 : 4'b0000);
      chk("rep rel long", long_a & 4'b0010, (c < 6) ? 4'b0010 : 4'b0000);
    end

    // Long press on ch2 for 7 ticks, then a 4-tick hold that stays short.
    s_a = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("long press en", en_a & 4'b0100, (c == 6) ? 4'b0100 : 4'b0000);
    end
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b1);
      chk($sformatf("long tick%0d", k), long_a & 4'b0100, (k >= 6) ? 4'b0100 : 4'b0000);
      for (int q = 0; q < 3; q++) begin
        cyc(1'b0);
        chk($sformatf("long quiet%0d", k), long_a & 4'b0100, (k >= 5) ? 4'b0100 : 4'b0000);
      end
    end
    s_a = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("long rel", rel_a & 4'b0100, (c == 6) ? 4'b0100 : 4'b0000);
      chk("long rel long", long_a & 4'b0100, (c < 6) ? 4'b0100 : 4'b0000);
    end
    s_a = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("short press", press_a & 4'b0100, (c == 6) ? 4'b0100 : 4'b0000);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1);
      chk("short tick", long_a & 4'b0100, 4'b0000);
      for (int q = 0; q < 3; q++) begin
        cyc(1'b0);
        chk("short quiet", long_a & 4'b0100, 4'b0000);
      end
    end
    s_a = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("short rel", rel_a & 4'b0100, (c == 6) ? 4'b0100 : 4'b0000);
      chk("short rel long", long_a & 4'b0100, 4'b0000);
    end

    // Active-low instance: ch3 pressed by driving 0, released by driving 1.
    s_b = 4'b0111;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("al en", en_b, (c == 6) ? 4'b1000 : 4'b0000);
      chk("al press", press_b, (c == 6) ? 4'b1000 : 4'b0000);
    end
    s_b = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      cyc(1'b0);
      chk("al rel", rel_b, (c == 6) ? 4'b1000 : 4'b0000);
    end
    chk("al en off", en_b, 4'b0000);

    // Simultaneous press on ch0 and ch3, long hold, then clear mid-hold.
    s_a = 4'b1001;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("multi press", press_a, (c == 6) ? 4'b1001 : 4'b0000);
      chk("multi up", up_a, (c == 6) ? 4'b1001 : 4'b0000);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1);
      for (int q = 0; q < 3; q++) cyc(1'b0);
    end
    chk("multi long", long_a, 4'b1001);
    chk("multi en", en_a, 4'b1001);
    CLR = 1'b1;
    cyc(1'b0);
    chk("clr en", en_a, 4'b0000);
    chk("clr long", long_a, 4'b0000);
    chk("clr rel", rel_a, 4'b0000);
    CLR = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0);
      chk("post clr rel", rel_a, 4'b0000);
      chk("post clr en", en_a, (c == 6) ? 4'b1001 : 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_key_debouncer.md
Name: multi_key_debouncer

Overview:
- N-channel successor to the single-switch debouncer.
- Each channel has:
  - a 2-flop input synchronizer
  - a BITS_NUM-sample shift filter with hysteresis, so the debounced state changes only on BITS_NUM identical samples
  - separate press and release event pulses
  - per-channel auto-repeat with a programmable start delay and period
  - a long-press level flag
- Sits between the raw push-button pins and the countdown-timer control FSM.

Parameters:
- CH_NUM, 4, number of independent key channels (≥1).
- BITS_NUM, 4, consecutive CE samples required to change the debounced state (≥2).
- ACTIVE_LOW, 0, 1 = pressed key reads 0 on S_IN; inversion happens before the synchronizer.
- REPEAT_START_DELAY, 50, REP_CE ticks from press to the first repeat pulse (≥1).
- REPEAT_PERIOD, 10, REP_CE ticks between subsequent repeat pulses (≥1).
- LONG_DELAY, 200, REP_CE ticks of continuous hold before KEY_LONG asserts (≥1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- CLR  in  1  synchronous, active-high reset.
- CE  in  1  sample strobe for the debounce filter, one-cycle pulse.
- REP_CE  in  1  timebase strobe for the repeat and long-press counters.
- S_IN  in  CH_NUM  raw switch inputs, asynchronous.
- REP_EN  in  CH_NUM  per-channel auto-repeat enable; sampled every cycle.
- KEY_EN  out  CH_NUM  debounced pressed state (level).
- KEY_PRESS  out  CH_NUM  one-cycle pulse on a debounced press.
- KEY_REL  out  CH_NUM  one-cycle pulse on a debounced release.
- KEY_UP  out  CH_NUM  one-cycle pulse on a press or on each auto-repeat.
- KEY_LONG  out  CH_NUM  high while held for at least LONG_DELAY REP_CE ticks.

Behaviour:
- Reset: CLR=1 clears every register (sync flops, shift filters, debounced state, counters) and drives all outputs to 0.
  - CLR has priority over CE, REP_CE and all events.
  - CLR asserted mid-hold drops KEY_EN and KEY_LONG without a KEY_REL pulse.
- Registered outputs: all outputs are registered. No combinational path exists from any input to any output.
- Synchronizer:
  - x = S_IN[i] XOR ACTIVE_LOW.
  - Two flops, clocked every cycle regardless of CE.
  - s = second-flop output.
- Shift filter: on a CE=1 edge, SR <= {SR[BITS_NUM-2:0], s}. SR holds while CE=0.
- Set condition: CE & s & (&SR[BITS_NUM-2:0]) & ~D.
  - D <= 1, KEY_PRESS <= 1 and KEY_UP <= 1, all on the same edge.
- Clear condition: CE & ~s & ~(|SR[BITS_NUM-2:0]) & D.
  - D <= 0 and KEY_REL <= 1.
- Hysteresis: mixed sample patterns leave D unchanged, so there is no chatter on a bouncy contact.
- Latency: with CE=1 every cycle and a clean step on S_IN, KEY_EN changes on the BITS_NUM+2-th rising edge after the step is first captured.
- KEY_EN = D.
- Pulse width: KEY_PRESS, KEY_REL and KEY_UP are high for exactly one clock, then return to 0 unless re-triggered.
- Repeat counter RC per channel, width $clog2(max(REPEAT_START_DELAY,REPEAT_PERIOD)):
  - On the set edge, RC <= REPEAT_START_DELAY-1. This load wins over a coincident REP_CE.
  - While D=1 and REP_EN[i]=1, on a REP_CE edge:
    - if RC==0: KEY_UP <= 1 and RC <= REPEAT_PERIOD-1;
    - otherwise RC <= RC-1.
  - With REP_EN[i]=0, RC holds and no repeat pulses occur. Re-enabling resumes from the held value.
  - On release (D=0), RC is don't-care and is reloaded on the next press.
- Hold counter HC per channel, width $clog2(LONG_DELAY+1):
  - Cleared on the set edge and whenever D=0.
  - While D=1, increments on REP_CE and saturates at LONG_DELAY.
  - KEY_LONG <= (HC==LONG_DELAY) & D. It is registered, so it asserts the clock after HC reaches LONG_DELAY.
  - KEY_LONG deasserts on the clear edge, together with KEY_REL.
- Channel independence: channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Simultaneous CE and REP_CE on one channel:
  - the set edge takes precedence (load RC, clear HC);
  - on the clear edge the counters are ignored.

Test Plan:
- Reset check: CLR=1 for 3 clocks with S_IN=4'hF held → all outputs 0. After CLR falls (CE=1 every cycle), KEY_EN=4'hF on the 6th edge, with KEY_PRESS=KEY_UP=4'hF for exactly 1 clock.
- Bounce filter: ch0 with S_IN toggling 1,0,1,1,0,1 per CE → KEY_EN[0] stays 0. Then 4 steady 1s → KEY_EN[0]=1 and one KEY_PRESS. Then 3 zeros and a one → KEY_EN[0] stays 1 (hysteresis).
- Auto-repeat: REPEAT_START_DELAY=3, REPEAT_PERIOD=2, REP_EN=1, REP_CE every 4 clocks, ch1 held → KEY_UP[1] at press, then on the 3rd REP_CE, then every 2nd REP_CE. Setting REP_EN[1]=0 stops the pulses while KEY_EN[1] stays 1.
- Long press: LONG_DELAY=5, ch2 held for 7 REP_CE ticks → KEY_LONG[2] rises 1 clock after the 5th tick. On release, KEY_LONG[2]=0 and a KEY_REL[2] pulse occur on the same edge. A hold of 4 ticks → KEY_LONG[2] never asserts.
- ACTIVE_LOW=1, ch3 with S_IN[3]=0 held → KEY_EN[3]=1. Returning to 1 for 4 CE samples → a single KEY_REL[3] pulse.
- Multi-channel and mid-hold reset: ch0 and ch3 pressed on the same cycle → both KEY_PRESS bits pulse together. CLR asserted while they are held → KEY_EN and KEY_LONG go to 0 on the next edge with no KEY_REL pulse.
